// File: rtl/gcd_engine.sv
// Parametrised GCD engine: subtractive Euclid (MODE=0) or binary Stein (MODE=1)
// behind a start/busy/done handshake, with a saturating per-operation iteration count.
module gcd_engine #(
  parameter int WIDTH = 32,
  parameter int MODE  = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] gcd_out,
  output logic [CNT_W-1:0] iter_count
);

  localparam int KW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN, S_FIN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic             done_q, done_d;

  logic             x_eq_y, x_gt_y, trivial;
  logic [CNT_W-1:0] cnt_inc;

  assign x_eq_y  = (x_q == y_q);
  assign x_gt_y  = (x_q > y_q);
  // Zero or equal operands need no iteration; the result is simply x|y.
  assign trivial = (x_q == '0) || (y_q == '0) || x_eq_y;
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      gcd_q   <= '0;
      iter_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      gcd_q   <= gcd_d;
      iter_q  <= iter_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CHECK;
      S_CHECK: state_d = trivial ? S_FIN : S_RUN;
      S_RUN:   if (x_eq_y) state_d = S_IDLE;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    k_d    = k_q;
    cnt_d  = cnt_q;
    gcd_d  = gcd_q;
    iter_d = iter_q;
    done_d = 1'b0;
    busy   = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d   = num1;
          y_d   = num2;
          k_d   = '0;
          cnt_d = '0;
        end
      end
      S_CHECK: begin
        if (trivial) x_d = x_q | y_q;
      end
      S_FIN: begin
        gcd_d  = x_q;
        iter_d = cnt_q;
        done_d = 1'b1;
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        if (x_eq_y) begin
          gcd_d  = (MODE == 0) ? x_q : (x_q << k_q);
          iter_d = cnt_inc;
          done_d = 1'b1;
        end else if (MODE == 0) begin
          if (x_gt_y) x_d = x_q - y_q;
          else        y_d = y_q - x_q;
        end else begin
          // Common factors of two are stripped into k and restored on finish.
          if (!x_q[0] && !y_q[0]) begin
            x_d = x_q >> 1;
            y_d = y_q >> 1;
            k_d = k_q + 1'b1;
          end else if (!x_q[0]) begin
            x_d = x_q >> 1;
          end else if (!y_q[0]) begin
            y_d = y_q >> 1;
          end else if (x_gt_y) begin
            x_d = (x_q - y_q) >> 1;
          end else begin
            y_d = (y_q - x_q) >> 1;
          end
        end
      end
      default: ;
    endcase
  end

  assign done       = done_q;
  assign gcd_out    = gcd_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Randomised self-checking bench for gcd_engine: Euclid and Stein instances plus a
// narrow saturating-counter instance, checked against a modulo-based reference model.
module tb_gcd_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  logic        start0 = 1'b0, start1 = 1'b0, start_s = 1'b0;
  logic [31:0] n1_0 = '0, n2_0 = '0, n1_1 = '0, n2_1 = '0;
  logic [7:0]  n1_s = '0, n2_s = '0;
  logic        busy0, done0, busy1, done1, busy_s, done_s;
  logic [31:0] gcd0, gcd1;
  logic [7:0]  gcd_s;
  logic [15:0] iter0, iter1;
  logic [3:0]  iter_s;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gcd_engine #(.WIDTH(32), .MODE(0), .CNT_W(16)) u_euclid (
    .clk(clk), .reset(reset), .start(start0), .num1(n1_0), .num2(n2_0),
    .busy(busy0), .done(done0), .gcd_out(gcd0), .iter_count(iter0));

  gcd_engine #(.WIDTH(32), .MODE(1), .CNT_W(16)) u_stein (
    .clk(clk), .reset(reset), .start(start1), .num1(n1_1), .num2(n2_1),
    .busy(busy1), .done(done1), .gcd_out(gcd1), .iter_count(iter1));

  gcd_engine #(.WIDTH(8), .MODE(0), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .start(start_s), .num1(n1_s), .num2(n2_s),
    .busy(busy_s), .done(done_s), .gcd_out(gcd_s), .iter_count(iter_s));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: gcd by remainders; subtractive step count equals the sum of quotients.
  function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int ref_sub_iters(input logic [31:0] a, input logic [31:0] b);
    int s;
    logic [31:0] t;
    if (a == 0 || b == 0 || a == b) return 0;
    s = 0;
    while (b != 0) begin
      s += int'(a / b);
      t = a % b;
      a = b;
      b = t;
    end
    return s;
  endfunction

  function automatic int ref_stein_iters(input logic [31:0] a, input logic [31:0] b);
    int n;
    if (a == 0 || b == 0 || a == b) return 0;
    n = 0;
    forever begin
      n++;
      if (a == b) break;
      if (a % 2 == 0 && b % 2 == 0) begin a = a / 2; b = b / 2; end
      else if (a % 2 == 0) a = a / 2;
      else if (b % 2 == 0) b = b / 2;
      else if (a > b) a = (a - b) / 2;
      else b = (b - a) / 2;
    end
    return n;
  endfunction

  // Launches one op on each 32-bit engine and checks result, count, latency and busy/done.
  task automatic do_op(input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1);
    int t0, lat0, lat1, bviol, ei0, ei1;
    logic seen0, seen1;
    logic [31:0] g0, g1;
    logic [15:0] i0, i1;
    @(negedge clk);
    n1_0 = a0; n2_0 = b0; n1_1 = a1; n2_1 = b1;
    start0 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    t0 = cyc; start0 = 1'b0; start1 = 1'b0;
    seen0 = 1'b0; seen1 = 1'b0; bviol = 0;
    lat0 = -1; lat1 = -1; g0 = '0; g1 = '0; i0 = '0; i1 = '0;
    for (int c = 0; c < 3000 && !(seen0 && seen1); c++) begin
      if (!seen0) begin
        if (done0) begin
          seen0 = 1'b1; lat0 = cyc - t0; g0 = gcd0; i0 = iter0;
          if (busy0) bviol++;
        end else if (!busy0) bviol++;
      end
      if (!seen1) begin
        if (done1) begin
          seen1 = 1'b1; lat1 = cyc - t0; g1 = gcd1; i1 = iter1;
          if (busy1) bviol++;
        end else if (!busy1) bviol++;
      end
      if (!(seen0 && seen1)) begin
        @(posedge clk); #1;
      end
    end
    ei0 = ref_sub_iters(a0, b0);
    ei1 = ref_stein_iters(a1, b1);
    check_eq("euclid_done_seen", seen0, 1'b1);
    check_eq("stein_done_seen", seen1, 1'b1);
    check_eq("euclid_gcd", g0, ref_gcd(a0, b0));
    check_eq("euclid_iter", i0, ei0);
    check_eq("euclid_latency", lat0, (ei0 == 0) ? 2 : 1 + ei0);
    check_eq("stein_gcd", g1, ref_gcd(a1, b1));
    check_eq("stein_iter", i1, ei1);
    check_eq("stein_latency", lat1, (ei1 == 0) ? 2 : 1 + ei1);
    check_eq("busy_done_protocol", bviol, 0);
    $display("op euclid(%0d,%0d)->%0d it %0d | stein(%0d,%0d)->%0d it %0d",
             a0, b0, g0, i0, a1, b1, g1, i1);
  endtask

  task automatic sat_op(input logic [7:0] a, input logic [7:0] b);
    int t0, lat, ei;
    @(negedge clk);
    n1_s = a; n2_s = b; start_s = 1'b1;
    @(posedge clk); #1;
    t0 = cyc; start_s = 1'b0; lat = -1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (done_s) begin lat = cyc - t0; break; end
    end
    ei = ref_sub_iters({24'd0, a}, {24'd0, b});
    check_eq("sat_gcd", gcd_s, ref_gcd({24'd0, a}, {24'd0, b}));
    check_eq("sat_iter", iter_s, (ei > 15) ? 15 : ei);
    check_eq("sat_latency", lat, (ei == 0) ? 2 : 1 + ei);
    $display("op sat(%0d,%0d)->%0d it %0d", a, b, gcd_s, iter_s);
  endtask

  task automatic wait_done0(input int t0, output int lat);
    lat = -1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (done0) begin lat = cyc - t0; break; end
    end
  endtask

  initial begin
    int t0, lat, late_done;
    logic [31:0] a0, b0, a1, b1;

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_busy", busy0, 1'b0);
    check_eq("reset_done", done0, 1'b0);
    check_eq("reset_gcd", gcd1, 32'd0);
    check_eq("reset_iter", iter1, 16'd0);
    @(negedge clk); reset = 1'b1;

    // Worked examples from the datasheet
    do_op(32'd12, 32'd8, 32'd12, 32'd8);
    do_op(32'd0, 32'd9, 32'd0, 32'd9);
    do_op(32'd0, 32'd0, 32'd0, 32'd0);
    do_op(32'd7, 32'd7, 32'd7, 32'd7);
    do_op(32'd9, 32'd0, 32'd9, 32'd0);
    do_op(32'd8, 32'd12, 32'h8000_0000, 32'h4000_0000);

    // Reset asserted mid-run clears outputs at once and suppresses done
    @(negedge clk);
    n1_0 = 32'd1000; n2_0 = 32'd1; start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    repeat (20) @(posedge clk);
    #3; reset = 1'b0; #1;
    check_eq("abort_busy", busy0, 1'b0);
    check_eq("abort_done", done0, 1'b0);
    check_eq("abort_gcd", gcd0, 32'd0);
    check_eq("abort_iter", iter0, 16'd0);
    check_eq("abort_stein_gcd", gcd1, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    late_done = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done0 || busy0) late_done++;
    end
    check_eq("abort_no_done", late_done, 0);
    do_op(32'd12, 32'd8, 32'd12, 32'd8);

    // start held high: second op latches the operands present in the done cycle
    @(negedge clk);
    n1_0 = 32'd12; n2_0 = 32'd8; start0 = 1'b1;
    @(posedge clk); #1;
    t0 = cyc; n1_0 = 32'd9; n2_0 = 32'd6;
    wait_done0(t0, lat);
    check_eq("b2b_first_latency", lat, 4);
    check_eq("b2b_first_gcd", gcd0, 32'd4);
    wait_done0(t0, lat);
    check_eq("b2b_second_latency", lat, 9);
    check_eq("b2b_second_gcd", gcd0, 32'd3);
    check_eq("b2b_second_iter", iter0, 16'd3);
    @(negedge clk); start0 = 1'b0;
    @(posedge clk); #1;
    check_eq("b2b_idle_after", busy0, 1'b0);
    $display("op back-to-back euclid (12,8) then (9,6)");

    // Saturating iteration counter on a narrow instance
    sat_op(8'd12, 8'd8);
    sat_op(8'd255, 8'd1);
    sat_op(8'd200, 8'd3);

    for (int n = 0; n < 400; n++) begin
      a0 = $urandom_range(0, 600);
      b0 = $urandom_range(1, 600);
      a1 = $urandom;
      b1 = $urandom;
      if (n % 20 == 0) a0 = 32'd0;
      if (n % 23 == 0) b0 = a0;
      if (n % 31 == 0) b1 = a1;
      if (n % 37 == 0) a1 = 32'd0;
      if (n % 11 == 0) b1 = b1 << (n % 17);
      do_op(a0, b0, a1, b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
